pow2_share_arbiter: RTL



---
 rtl/pow2_pkg.sv | 26 ++
 rtl/pow2_share_arbiter_rr.sv | 34 +++
 rtl/pow2_share_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pow2_pkg.sv
// Shared definitions for the softmax_approx pow2 datapath: Q4.12 format,
// pow2_approx unit latency, and the request tag carried alongside the unit.
package pow2_pkg;

    // Q4.12 operand/result format.
    localparam int DW        = 16;
    localparam int FRAC_BITS = 12;

    // Number of enabled cycles from pow2_approx input to output.
    localparam int POW2_LAT  = 3;

    // Tag id field is sized for the largest supported requester count (8),
    // so one tag type serves every arbiter configuration.
    localparam int TAG_IDW   = 3;

    // Handy Q4.12 constants (1.0 and 2.0).
    localparam logic [DW-1:0] ONE_Q412 = 16'h1000;
    localparam logic [DW-1:0] TWO_Q412 = 16'h2000;

    // One slot of the tag pipeline: valid bit plus issuing requester id.
    typedef struct packed {
        logic               v;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/pow2_share_arbiter_rr.sv
// Combinational round-robin arbiter. Searches req starting at ptr and
// wrapping modulo N_REQ; the first asserted request wins.
module rr_arbiter
    import pow2_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx,
    output logic             grant_any
);

    logic [IDW-1:0] cand;

    // Rotating priority search: offset 0 is the pointer position itself.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = IDW'((int'(ptr) + off) % N_REQ);
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/pow2_share_arbiter.sv
// Shares one pow2_approx pipeline among N_REQ requesters. A round-robin
// arbiter picks at most one operand per cycle; a tag pipeline running in
// lock-step with the unit routes each result back to its issuer and
// cross-checks the unit's valid output.
//
// Handshake: an operand transfers on a cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is the one-hot grant and is never
// high during hold or rst. Responses (rsp_valid) have no backpressure and
// stay stable while hold is high; a response is new only on the first
// cycle it appears after an enabled edge.
//
// Optional build macro: POW2_ARB_PERF_CNT_EN adds per-requester 16-bit
// saturating accept counters (perf_cnt) and a synchronous clear (perf_clr).
module pow2_share_arbiter
    import pow2_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = pow2_pkg::DW,
    parameter int LAT   = pow2_pkg::POW2_LAT,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_x,
    output logic [N_REQ-1:0]    req_ready,
    output logic                pu_en,
    output logic                pu_ready,
    output logic [DW-1:0]       pu_in_x,
    input  logic [DW-1:0]       pu_pow2_x,
    input  logic [DW-1:0]       pu_out_x,
    input  logic                pu_valid,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_pow2,
    output logic [DW-1:0]       rsp_x,
    output logic                busy,
    output logic                err
`ifdef POW2_ARB_PERF_CNT_EN
    ,
    output logic [N_REQ*16-1:0] perf_cnt,
    input  logic                perf_clr
`endif
);

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             accept;

    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    tag_t             tag_q [LAT];
    tag_t             tag_d [LAT];
    tag_t             tail;
    logic             err_q, err_d;
    logic             any_v;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // The unit advances whenever the datapath is not stalled; it shares rst.
    assign pu_en  = ~hold;

    // A grant is only offered when the unit will actually take it.
    assign accept    = grant_any & ~hold & ~rst;
    assign req_ready = accept ? grant : '0;
    assign pu_ready  = |req_ready;

    // Mux the granted operand into the unit; zero when idle.
    always_comb begin
        pu_in_x = '0;
        if (accept) begin
            pu_in_x = req_x[int'(grant_idx)*DW +: DW];
        end
    end

    // Pointer moves just past the requester that was served.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Tag shift mirrors the unit's stage enables exactly.
    always_comb begin
        tag_d = tag_q;
        if (pu_en) begin
            tag_d[0].v  = pu_ready;
            tag_d[0].id = TAG_IDW'(grant_idx);
            for (int i = 1; i < LAT; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    // Tag pipeline registers; in-flight work is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tail     = tag_q[LAT-1];
    assign rsp_pow2 = pu_pow2_x;
    assign rsp_x    = pu_out_x;

    // Decode the tail tag into a one-hot response strobe.
    always_comb begin
        rsp_valid = '0;
        if (!rst && tail.v) begin
            for (int i = 0; i < N_REQ; i++) begin
                rsp_valid[i] = (tail.id == TAG_IDW'(i));
            end
        end
    end

    // Busy whenever any slot of the tag pipeline holds live work.
    always_comb begin
        any_v = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            any_v = any_v | tag_q[i].v;
        end
        busy = any_v & ~rst;
    end

    // Sticky flag: the unit's valid must track our own tail tag every cycle.
    always_comb begin
        err_d = err_q | (pu_valid != tail.v);
    end

    // Error flag register; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q & ~rst;

`ifdef POW2_ARB_PERF_CNT_EN
    logic [15:0] cnt_q [N_REQ];
    logic [15:0] cnt_d [N_REQ];

    // Count accepted operands per requester, saturating at all-ones.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (perf_clr) begin
                cnt_d[i] = '0;
            end else if (req_ready[i] && req_valid[i] && cnt_q[i] != 16'hFFFF) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flatten counters onto the packed output bus.
    always_comb begin
        perf_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            perf_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule
